level_code_encoder: RTL and testbench

LEVEL_CODE_ENCODER -- requirements
Module: level_code_encoder

---
 rtl/level_code_encoder.sv | 124 ++++++++++++
 tb/tb_level_code_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_code_encoder.sv
// level_code_encoder: turns a block of signed coefficient levels into variable-length codewords
// (trailing-one sign bits, then prefix/suffix level codes with an adaptive suffix length).
module level_code_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [4:0]  TotalCoeff,
    input  logic [1:0]  TrailingOnes,
    input  logic [12:0] LevelIn,
    input  logic        LevelValid,
    output logic        LevelReady,
    output logic [27:0] CodeOut,
    output logic [4:0]  CodeLen,
    output logic        CodeValid,
    input  logic        CodeReady,
    output logic        Busy,
    output logic        Done,
    output logic        RangeErr
);
    typedef enum logic [1:0] {IDLE, T1, LEVEL, DRAIN} state_t;
    state_t state, state_nx;
    logic [4:0] cnt, prefix, len_nx;
    logic [1:0] t1_cnt, t1_tot;
    logic [2:0] sl, sl_one, sl_nx;
    logic first, accept, start_ok, start_bad, level_err, pm_one;
    logic [13:0] lc0, lc, mag, thr, esc;
    logic [27:0] code_nx;

    assign Busy       = state != IDLE;
    assign LevelReady = (state == T1 || state == LEVEL) && (!CodeValid || CodeReady);
    assign accept     = LevelValid && LevelReady;
    assign start_bad  = Start && state == IDLE && (TotalCoeff > 5'd16 || {3'b0, TrailingOnes} > TotalCoeff);
    assign start_ok   = Start && state == IDLE && !start_bad;
    assign pm_one     = LevelIn == 13'h0001 || LevelIn == 13'h1fff;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = TotalCoeff == 5'd0 ? DRAIN : TrailingOnes != 2'd0 ? T1 : LEVEL;
            T1:      if (accept) state_nx = cnt == 5'd1 ? DRAIN : t1_cnt == 2'd1 ? LEVEL : T1;
            LEVEL:   if (accept && cnt == 5'd1) state_nx = DRAIN;
            DRAIN:   if (!CodeValid || CodeReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // levelCode arithmetic is modulo 2^14; illegal levels simply wrap and are flagged
    always_comb begin
        lc0 = (LevelIn[12] || LevelIn == 13'd0) ? ~{LevelIn, 1'b0} : {LevelIn, 1'b0} - 14'd2;
        lc = (first && t1_tot != 2'd3) ? lc0 - 14'd2 : lc0;
        mag = LevelIn[12] ? 14'd0 - {1'b1, LevelIn} : {1'b0, LevelIn};
        thr = 14'd15 << sl;
        esc = lc - (sl == 3'd0 ? 14'd30 : thr);
        prefix = 5'(lc >> sl);
        code_nx = 28'd1;
        len_nx = 5'd1;
        level_err = 1'b0;
        if (state == T1) begin
            code_nx = {27'd0, LevelIn[12]};
            level_err = !pm_one;
        end else begin
            level_err = LevelIn == 13'd0 || (first && t1_tot != 2'd3 && pm_one);
            if (sl == 3'd0 && lc < 14'd14) begin
                len_nx = lc[4:0] + 5'd1;
            end else if (sl == 3'd0 && lc < 14'd30) begin
                code_nx = {23'd0, 1'b1, lc[3:0] - 4'd14};
                len_nx = 5'd19;
            end else if (sl != 3'd0 && lc < thr) begin
                code_nx = (28'd1 << sl) | {14'd0, lc & ((14'd1 << sl) - 14'd1)};
                len_nx = prefix + {2'b0, sl} + 5'd1;
            end else begin
                code_nx = {15'd0, 1'b1, esc[11:0]};
                len_nx = 5'd28;
                level_err = level_err || esc[13:12] != 2'd0;
            end
        end
        sl_one = sl == 3'd0 ? 3'd1 : sl;
        sl_nx = (mag > (14'd3 << (sl_one - 3'd1)) && sl_one < 3'd6) ? sl_one + 3'd1 : sl_one;
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt <= 5'd0;
            t1_cnt <= 2'd0;
            t1_tot <= 2'd0;
            sl <= 3'd0;
            first <= 1'b0;
            CodeOut <= 28'd0;
            CodeLen <= 5'd0;
            CodeValid <= 1'b0;
            Done <= 1'b0;
            RangeErr <= 1'b0;
        end else begin
            Done <= state == DRAIN && (!CodeValid || CodeReady);
            RangeErr <= start_bad || (accept && level_err);
            if (start_ok) begin
                cnt <= TotalCoeff;
                t1_cnt <= TrailingOnes;
                t1_tot <= TrailingOnes;
                sl <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
                first <= 1'b1;
            end
            if (accept) begin
                cnt <= cnt - 5'd1;
                CodeOut <= code_nx;
                CodeLen <= len_nx;
                CodeValid <= 1'b1;
                if (state == T1) begin
                    t1_cnt <= t1_cnt - 2'd1;
                end else begin
                    sl <= sl_nx;
                    first <= 1'b0;
                end
            end else if (CodeReady) begin
                CodeValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_level_code_encoder.sv
// tb_level_code_encoder: directed and randomized blocks checked cycle by cycle against an
// arithmetic model of the level coding rules.
module tb_level_code_encoder;
    logic Clk = 1'b0, Reset, Start, LevelValid, CodeReady;
    logic LevelReady, CodeValid, Busy, Done, RangeErr;
    logic [4:0] TotalCoeff, CodeLen;
    logic [1:0] TrailingOnes;
    logic [12:0] LevelIn;
    logic [27:0] CodeOut;
    int ntests = 0, nfail = 0, err_seen;
    int lv[16];
    int act_code[$], act_len[$];

    level_code_encoder dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .TotalCoeff(TotalCoeff),
        .TrailingOnes(TrailingOnes), .LevelIn(LevelIn), .LevelValid(LevelValid),
        .LevelReady(LevelReady), .CodeOut(CodeOut), .CodeLen(CodeLen), .CodeValid(CodeValid),
        .CodeReady(CodeReady), .Busy(Busy), .Done(Done), .RangeErr(RangeErr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"}, CodeOut, 0);
        check({tag, "_len"}, CodeLen, 0);
        check({tag, "_cv"}, CodeValid, 0);
        check({tag, "_lr"}, LevelReady, 0);
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_rerr"}, RangeErr, 0);
    endtask

    task automatic model_code(input int level, input int idx, input int t1, inout int sl,
                              output int code, output int len, output bit err);
        int lc, base, s, mag;
        bit escape;
        if (idx < t1) begin
            code = level < 0 ? 1 : 0;
            len = 1;
            err = level != 1 && level != -1;
            return;
        end
        err = level == 0 || (idx == t1 && t1 < 3 && (level == 1 || level == -1));
        lc = level > 0 ? 2 * level - 2 : -2 * level - 1;
        if (idx == t1 && t1 < 3) lc -= 2;
        lc = lc & 16383;
        escape = 0;
        base = 0;
        if (sl == 0) begin
            if (lc < 14) begin code = 1; len = lc + 1; end
            else if (lc < 30) begin code = 16 + lc - 14; len = 19; end
            else begin escape = 1; base = 30; end
        end else if (lc < 15 * (1 << sl)) begin
            code = (1 << sl) + lc % (1 << sl);
            len = lc / (1 << sl) + 1 + sl;
        end else begin
            escape = 1;
            base = 15 * (1 << sl);
        end
        if (escape) begin
            s = lc - base;
            err = err || s > 4095;
            code = 4096 + s % 4096;
            len = 28;
        end
        mag = level < 0 ? -level : level;
        if (sl == 0) sl = 1;
        if (mag > 3 * (1 << (sl - 1)) && sl < 6) sl++;
    endtask

    task automatic fill_levels(input int t1);
        int r, m;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            m = r < 6 ? $urandom_range(1, 8) : r < 9 ? $urandom_range(1, 200) : $urandom_range(1, 2000);
            if (i < t1) m = 1;
            else if (i == t1 && t1 < 3 && m == 1) m = 2;
            lv[i] = $urandom_range(0, 1) ? -m : m;
        end
    endtask

    task automatic run_block(input int tc, input int t1, input int vp, input int rp, input int hold);
        int idx, sl, cyc, pcode, plen, code, len;
        bit pend, err, drain, fin, acc, rdy, done_nx, rerr_nx;
        sl = (tc > 10 && t1 < 3) ? 1 : 0;
        act_code.delete();
        act_len.delete();
        err_seen = 0;
        Start = 1'b1;
        TotalCoeff = 5'(tc);
        TrailingOnes = 2'(t1);
        @(posedge Clk); #1;
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
        idx = 0; pend = 0; drain = tc == 0; fin = 0; cyc = 0;
        while (!fin && cyc < 400) begin
            LevelValid = idx < tc && $urandom_range(0, 99) < vp;
            LevelIn = 13'(idx < tc ? lv[idx] : int'($urandom));
            CodeReady = (cyc >= 1 && cyc < 1 + hold) ? 1'b0 : $urandom_range(0, 99) < rp;
            Start = $urandom_range(0, 9) == 0;
            TotalCoeff = 5'($urandom);
            TrailingOnes = 2'($urandom);
            #1;
            rdy = idx < tc && (!pend || CodeReady);
            check("level_ready", LevelReady, rdy);
            acc = LevelValid && rdy;
            done_nx = drain && (!pend || CodeReady);
            rerr_nx = 0;
            if (acc) begin
                model_code(lv[idx], idx, t1, sl, code, len, err);
                pend = 1; pcode = code; plen = len; rerr_nx = err;
                idx++;
                drain = idx == tc;
            end else if (CodeReady) begin
                pend = 0;
            end
            if (done_nx) begin drain = 0; fin = 1; end
            @(posedge Clk); #1;
            Start = 1'b0;
            check("code_valid", CodeValid, pend);
            if (pend) begin
                check("code_out", CodeOut, pcode);
                check("code_len", CodeLen, plen);
            end
            check("range_err", RangeErr, rerr_nx);
            check("done", Done, done_nx);
            check("busy", Busy, !fin);
            if (acc) begin act_code.push_back(int'(CodeOut)); act_len.push_back(int'(CodeLen)); end
            if (RangeErr) err_seen++;
            cyc++;
        end
        check("block_finished", fin, 1);
        LevelValid = 1'b0;
        CodeReady = 1'b1;
    endtask

    task automatic check_list(input string tag, input int codes[5], input int lens[5], input int n);
        check({tag, "_count"}, act_code.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_code"}, act_code.size() > i ? act_code[i] : -1, codes[i]);
            check({tag, "_len"}, act_len.size() > i ? act_len[i] : -1, lens[i]);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; TotalCoeff = 5'd0; TrailingOnes = 2'd0;
        LevelIn = 13'd0; LevelValid = 1'b0; CodeReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;

        lv[0] = 1; lv[1] = 1; lv[2] = -1; lv[3] = -1; lv[4] = 3;
        run_block(5, 3, 100, 100, 0);
        check_list("t1_block", '{0, 0, 1, 1, 2}, '{1, 1, 1, 2, 4}, 5);

        lv[0] = 2;
        run_block(1, 0, 100, 100, 0);
        check_list("level2", '{1, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, 1);
        lv[0] = 9;
        run_block(1, 0, 100, 100, 0);
        check_list("level9", '{16, 0, 0, 0, 0}, '{19, 0, 0, 0, 0}, 1);

        fill_levels(0);
        lv[0] = 3;
        run_block(11, 0, 100, 100, 0);
        check("sl_init_code", act_code.size() > 0 ? act_code[0] : -1, 2);
        check("sl_init_len", act_len.size() > 0 ? act_len[0] : -1, 3);

        fill_levels(1);
        run_block(6, 1, 100, 100, 3);
        check("hold_count", act_code.size(), 6);

        lv[0] = 2; lv[1] = 5;
        run_block(2, 1, 100, 100, 0);
        check("t1_bad_errs", err_seen, 1);
        lv[0] = 5; lv[1] = 0; lv[2] = 7;
        run_block(3, 0, 100, 100, 0);
        check("zero_level_errs", err_seen, 1);
        lv[0] = -1; lv[1] = 1;
        run_block(2, 1, 100, 100, 0);
        check("first_pm1_errs", err_seen, 1);
        lv[0] = 4000;
        run_block(1, 0, 100, 100, 0);
        check("escape_overflow_errs", err_seen, 1);

        Start = 1'b1; TotalCoeff = 5'd1; TrailingOnes = 2'd2;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("bad_start_rerr", RangeErr, 1);
        check("bad_start_busy", Busy, 0);
        @(posedge Clk); #1;
        check("bad_start_rerr_pulse", RangeErr, 0);
        check("bad_start_busy2", Busy, 0);
        Start = 1'b1; TotalCoeff = 5'd17; TrailingOnes = 2'd0;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("tc17_rerr", RangeErr, 1);
        check("tc17_busy", Busy, 0);

        Start = 1'b1; TotalCoeff = 5'd4; TrailingOnes = 2'd0;
        @(posedge Clk); #1;
        Start = 1'b0; LevelValid = 1'b1; LevelIn = 13'd5; CodeReady = 1'b0;
        @(posedge Clk); #1;
        check("pre_reset_cv", CodeValid, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check_idle_outputs("mid_reset");
        Reset = 1'b0; LevelValid = 1'b0; CodeReady = 1'b1;
        lv[0] = 9;
        run_block(1, 0, 100, 100, 0);
        check_list("after_reset", '{16, 0, 0, 0, 0}, '{19, 0, 0, 0, 0}, 1);

        for (int b = 0; b < 40; b++) begin
            int tc, t1;
            tc = $urandom_range(0, 16);
            t1 = $urandom_range(0, tc < 3 ? tc : 3);
            fill_levels(t1);
            run_block(tc, t1, $urandom_range(40, 100), $urandom_range(30, 100), 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
